// File: rtl/vpu_fp_dst_collector.sv
// Destination-side result collector for fixed-latency FP IP (e.g. SQRT).
// Buffers done/result pulses in a FIFO, drains them over a valid/ready
// write-back port tagged with the element index, and grants issue credits
// upstream so a result is never dropped under legal use.
// Optional feature macro: VPU_DST_BYPASS_EN (zero-latency empty-FIFO bypass).
module vpu_fp_dst_collector #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned NUM_ELEM   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        issue_i,
    output logic                        credit_ok_o,
    input  logic                        done_i,
    input  logic [DATA_WIDTH-1:0]       result_i,
    output logic                        wb_valid_o,
    input  logic                        wb_ready_i,
    output logic [DATA_WIDTH-1:0]       wb_data_o,
    output logic [$clog2(NUM_ELEM)-1:0] wb_idx_o,
    output logic                        wb_last_o,
    output logic                        err_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned IDX_W = $clog2(NUM_ELEM);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      inflight;
    logic [IDX_W-1:0]      idx_q;
    logic                  err_q;

    logic fifo_empty;
    logic fifo_full;
    logic bypass_hit;
    logic pop;
    logic fifo_pop;
    logic fifo_push;
    logic err_set;

    // FIFO status and write-back presentation (bypass path optional)
    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == CNT_W'(DEPTH));
`ifdef VPU_DST_BYPASS_EN
        bypass_hit = fifo_empty & done_i;
        wb_valid_o = ~fifo_empty | bypass_hit;
        if (!fifo_empty) begin
            wb_data_o = mem[rd_ptr];
        end else if (bypass_hit) begin
            wb_data_o = result_i;
        end else begin
            wb_data_o = '0;
        end
`else
        bypass_hit = 1'b0;
        wb_valid_o = ~fifo_empty;
        wb_data_o  = fifo_empty ? '0 : mem[rd_ptr];
`endif
        wb_idx_o  = idx_q;
        wb_last_o = wb_valid_o & (idx_q == IDX_W'(NUM_ELEM - 1));
        err_o     = err_q;
    end

    // Handshake decode: a bypassed entry consumed this cycle never enters the FIFO
    always_comb begin
        pop       = wb_valid_o & wb_ready_i;
        fifo_pop  = pop & ~fifo_empty;
        fifo_push = done_i & ~(bypass_hit & wb_ready_i) & (~fifo_full | fifo_pop);
        err_set   = (issue_i & ~credit_ok_o)
                  | (done_i & (inflight == '0))
                  | (done_i & fifo_full & ~pop);
    end

    // Credits cover both ops still inside the FP unit and results already buffered
    always_comb begin
        credit_ok_o = (SUM_W'(inflight) + SUM_W'(count)) < SUM_W'(DEPTH);
    end

    // Result storage; contents are only observed through valid entries
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            mem[wr_ptr] <= result_i;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({fifo_push, fifo_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // In-flight op tracking, saturating at DEPTH and at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else if (issue_i && !done_i) begin
            if (inflight != CNT_W'(DEPTH)) begin
                inflight <= inflight + CNT_W'(1);
            end
        end else if (done_i && !issue_i) begin
            if (inflight != '0) begin
                inflight <= inflight - CNT_W'(1);
            end
        end
    end

    // Element index advances on every accepted write-back entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else if (pop) begin
            idx_q <= (idx_q == IDX_W'(NUM_ELEM - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Sticky protocol error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vpu_fp_dst_collector.sv
// Directed bench for vpu_fp_dst_collector with a data scoreboard and an index model.
module tb_vpu_fp_dst_collector;

    localparam int unsigned DW = 32;
`ifdef VPU_DST_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          issue_i;
    logic          credit_ok_o;
    logic          done_i;
    logic [DW-1:0] result_i;
    logic          wb_valid_o;
    logic          wb_ready_i;
    logic [DW-1:0] wb_data_o;
    logic [3:0]    wb_idx_o;
    logic          wb_last_o;
    logic          err_o;

    vpu_fp_dst_collector #(.DATA_WIDTH(32), .DEPTH(8), .NUM_ELEM(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_i     (issue_i),
        .credit_ok_o (credit_ok_o),
        .done_i      (done_i),
        .result_i    (result_i),
        .wb_valid_o  (wb_valid_o),
        .wb_ready_i  (wb_ready_i),
        .wb_data_o   (wb_data_o),
        .wb_idx_o    (wb_idx_o),
        .wb_last_o   (wb_last_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            last_seen = 0;
    logic [DW-1:0] exp_q [$];
    logic [3:0]    exp_idx = 4'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted write-back entry is compared against the model
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (!rst_n) begin
            exp_idx = 4'd0;
        end else if (wb_valid_o && wb_ready_i) begin
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else                   e = 'x;
            chk("wb_data", wb_data_o, e);
            chk("wb_idx", 32'(wb_idx_o), 32'(exp_idx));
            chk("wb_last", 32'(wb_last_o), 32'(exp_idx == 4'd15));
            if (wb_last_o) last_seen++;
            exp_idx = exp_idx + 4'd1;
        end
    end

    // One cycle of stimulus; returns at the following negedge
    task automatic cyc(input logic iss, input logic dn, input logic [31:0] d,
                       input logic rdy, input logic sb);
        @(posedge clk);
        #1;
        issue_i    = iss;
        done_i     = dn;
        result_i   = d;
        wb_ready_i = rdy;
        if (dn && sb) exp_q.push_back(d);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        issue_i    = 1'b0;
        done_i     = 1'b0;
        wb_ready_i = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        issue_i    = 1'b0;
        done_i     = 1'b0;
        result_i   = '0;
        wb_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(wb_valid_o), 32'd0);
        chk("rst_data", wb_data_o, 32'd0);
        chk("rst_idx", 32'(wb_idx_o), 32'd0);
        chk("rst_last", 32'(wb_last_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_credit", 32'(credit_ok_o), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // T1: reset with three buffered entries discards them immediately
        do_reset();
        repeat (3) cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 32'hA0 + 32'(i), 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("t1_buffered_valid", 32'(wb_valid_o), 32'd1);
        chk("t1_buffered_data", wb_data_o, 32'hA0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("t1_midrst_valid", 32'(wb_valid_o), 32'd0);
        chk("t1_midrst_credit", 32'(credit_ok_o), 32'd1);
        chk("t1_midrst_data", wb_data_o, 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("t1_lost_valid", 32'(wb_valid_o), 32'd0);
        chk("t1_err", 32'(err_o), 32'd0);

        // T2: single op latency
        do_reset();
        cyc(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 32'h3FB504F3, 1'b1, 1'b1);
        chk("t2_valid_done_cycle", 32'(wb_valid_o), 32'(BYP));
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("t2_valid_next_cycle", 32'(wb_valid_o), 32'(!BYP));
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("t2_valid_after", 32'(wb_valid_o), 32'd0);
        chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("t2_err", 32'(err_o), 32'd0);

        // T3: backpressure, full, credits
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("t3_credit_before_8th", 32'(credit_ok_o), 32'd1);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("t3_credit_after_8th", 32'(credit_ok_o), 32'd0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 32'(i + 1), 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("t3_full_credit", 32'(credit_ok_o), 32'd0);
        chk("t3_full_valid", 32'(wb_valid_o), 32'd1);
        chk("t3_hold_data", wb_data_o, 32'd1);
        chk("t3_hold_idx", 32'(wb_idx_o), 32'd0);
        chk("t3_err", 32'(err_o), 32'd0);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("t3_credit_after_pop", 32'(credit_ok_o), 32'd1);
        repeat (7) cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("t3_drained", 32'(wb_valid_o), 32'd0);
        chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // T4: index wrap and last flag over 20 elements
        do_reset();
        last_seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
            cyc(1'b0, 1'b1, 32'h100 + 32'(i), 1'b1, 1'b1);
        end
        repeat (2) cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("t4_last_count", 32'(last_seen), 32'd1);
        chk("t4_final_idx", 32'(wb_idx_o), 32'd4);
        chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("t4_err", 32'(err_o), 32'd0);

        // T5a: push and pop together while full keeps occupancy and appends at the tail
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 32'h20 + 32'(i), 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("t5_full_err", 32'(err_o), 32'd0);
        cyc(1'b0, 1'b1, 32'h28, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("t5_still_full", 32'(credit_ok_o), 32'd0);
        chk("t5_new_head", wb_data_o, 32'h21);
        // nothing was dropped; only the no-op-in-flight condition can have fired
        chk("t5_err_inflight0", 32'(err_o), 32'd1);
        repeat (8) cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("t5_drained", 32'(wb_valid_o), 32'd0);
        chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

        // T5b: issue and done in the same cycle leave inflight unchanged
        do_reset();
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 32'h30, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("t5b_credit_full", 32'(credit_ok_o), 32'd0);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("t5b_credit_inflight7", 32'(credit_ok_o), 32'd1);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 32'h31 + 32'(i), 1'b1, 1'b1);
        repeat (2) cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("t5b_err", 32'(err_o), 32'd0);
        chk("t5b_sb_empty", 32'(exp_q.size()), 32'd0);

        // T6a: done with nothing in flight is flagged but buffered
        do_reset();
        cyc(1'b0, 1'b1, 32'hDEAD, 1'b0, 1'b1);
        chk("t6a_err_before", 32'(err_o), 32'd0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("t6a_err_set", 32'(err_o), 32'd1);
        chk("t6a_buffered_valid", 32'(wb_valid_o), 32'd1);
        chk("t6a_buffered_data", wb_data_o, 32'hDEAD);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("t6a_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("t6a_err_sticky", 32'(err_o), 32'd1);

        // T6b: done into a full FIFO without pop is dropped
        do_reset();
        chk("t6b_err_cleared", 32'(err_o), 32'd0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 32'h40 + 32'(i), 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("t6b_err_before", 32'(err_o), 32'd0);
        cyc(1'b0, 1'b1, 32'hBAD, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("t6b_err_set", 32'(err_o), 32'd1);
        chk("t6b_head", wb_data_o, 32'h40);
        repeat (8) cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("t6b_drained", 32'(wb_valid_o), 32'd0);
        chk("t6b_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
